// File: rtl/hash_match.sv
// Serial unsigned range check of a captured hash160 against [rx_min, rx_max], MSW first.
// Optional feature macro: HASH_MATCH_COUNT_EN builds the tx_checked_count register.
module hash_match #(
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rx_reset_n,
  input  logic             rx_done,
  input  logic [159:0]     rx_hash,
  input  logic [IDX_W-1:0] rx_index,
  input  logic [159:0]     rx_min,
  input  logic [159:0]     rx_max,
  input  logic             rx_match_ack,
  output logic             tx_busy,
  output logic             tx_match_valid,
  output logic [159:0]     tx_match_hash,
  output logic [IDX_W-1:0] tx_match_index,
  output logic [31:0]      tx_checked_count,
  output logic             tx_overrun
);

  typedef enum logic [1:0] {IDLE, CMP, REPORT} state_t;

  state_t           state_q, state_d;
  logic             done_q;
  logic [2:0]       widx_q, widx_d;
  logic             lo_eq_q, lo_eq_d, hi_eq_q, hi_eq_d;
  logic             lo_ok_q, lo_ok_d, hi_ok_q, hi_ok_d;
  logic             overrun_q, overrun_d;
  logic [159:0]     hash_q;
  logic [IDX_W-1:0] idx_q;
  logic             start, load;
  logic [31:0]      w, mn, mx;
  logic             lo_eq_n, lo_ok_n, hi_eq_n, hi_ok_n, match;

  function automatic logic [31:0] word_sel(input logic [159:0] v, input logic [2:0] i);
    case (i)
      3'd4:    word_sel = v[159:128];
      3'd3:    word_sel = v[127:96];
      3'd2:    word_sel = v[95:64];
      3'd1:    word_sel = v[63:32];
      default: word_sel = v[31:0];
    endcase
  endfunction

  assign start = rx_done & ~done_q;
  assign w     = word_sel(hash_q, widx_q);
  assign mn    = word_sel(rx_min, widx_q);
  assign mx    = word_sel(rx_max, widx_q);

  // Running per-bound verdict: once a word differs, later words no longer matter.
  always_comb begin
    lo_eq_n = lo_eq_q;
    lo_ok_n = lo_ok_q;
    hi_eq_n = hi_eq_q;
    hi_ok_n = hi_ok_q;
    if (lo_eq_q) begin
      if (w > mn) begin
        lo_ok_n = 1'b1;
        lo_eq_n = 1'b0;
      end else if (w < mn) begin
        lo_eq_n = 1'b0;
      end
    end
    if (hi_eq_q) begin
      if (w < mx) begin
        hi_ok_n = 1'b1;
        hi_eq_n = 1'b0;
      end else if (w > mx) begin
        hi_eq_n = 1'b0;
      end
    end
    match = (lo_ok_n | lo_eq_n) & (hi_ok_n | hi_eq_n);
  end

`ifdef HASH_MATCH_COUNT_EN
  logic [31:0] count_q, count_d;
`endif

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    lo_eq_d   = lo_eq_q;
    lo_ok_d   = lo_ok_q;
    hi_eq_d   = hi_eq_q;
    hi_ok_d   = hi_ok_q;
    load      = 1'b0;
    overrun_d = overrun_q | (start & (state_q != IDLE));
`ifdef HASH_MATCH_COUNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          widx_d  = 3'd4;
          lo_eq_d = 1'b1;
          hi_eq_d = 1'b1;
          lo_ok_d = 1'b0;
          hi_ok_d = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        lo_eq_d = lo_eq_n;
        lo_ok_d = lo_ok_n;
        hi_eq_d = hi_eq_n;
        hi_ok_d = hi_ok_n;
        widx_d  = widx_q - 3'd1;
        if (widx_q == 3'd0) begin
`ifdef HASH_MATCH_COUNT_EN
          count_d = count_q + 32'd1;
`endif
          state_d = match ? REPORT : IDLE;
        end
      end
      REPORT: begin
        if (rx_match_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      widx_q    <= 3'd0;
      lo_eq_q   <= 1'b0;
      lo_ok_q   <= 1'b0;
      hi_eq_q   <= 1'b0;
      hi_ok_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef HASH_MATCH_COUNT_EN
      count_q   <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= rx_done;
      widx_q    <= widx_d;
      lo_eq_q   <= lo_eq_d;
      lo_ok_q   <= lo_ok_d;
      hi_eq_q   <= hi_eq_d;
      hi_ok_q   <= hi_ok_d;
      overrun_q <= overrun_d;
`ifdef HASH_MATCH_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  // Candidate data needs no reset; it is only visible while REPORT gates it out.
  always_ff @(posedge clk) begin
    if (load) begin
      hash_q <= rx_hash;
      idx_q  <= rx_index;
    end
  end

  assign tx_busy        = (state_q != IDLE);
  assign tx_match_valid = (state_q == REPORT);
  assign tx_match_hash  = tx_match_valid ? hash_q : '0;
  assign tx_match_index = tx_match_valid ? idx_q : '0;
  assign tx_overrun     = overrun_q;
`ifdef HASH_MATCH_COUNT_EN
  assign tx_checked_count = count_q;
`else
  assign tx_checked_count = 32'd0;
`endif

endmodule

// File: tb/tb_hash_match.sv
// Directed bench for hash_match: match, off-by-one misses, overrun, async reset.
module tb_hash_match;
  logic         clk = 1'b0;
  logic         rx_reset_n;
  logic         rx_done;
  logic [159:0] rx_hash, rx_min, rx_max;
  logic [31:0]  rx_index;
  logic         rx_match_ack;
  logic         tx_busy, tx_match_valid, tx_overrun;
  logic [159:0] tx_match_hash;
  logic [31:0]  tx_match_index, tx_checked_count;

  int nchk = 0;
  int nerr = 0;

`ifdef HASH_MATCH_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  localparam logic [159:0] H1   = 160'h00112233_44556677_8899AABB_CCDDEEFF_01234567;
  localparam logic [159:0] H2   = 160'hDEADBEEF_00000000_11111111_22222222_33333333;
  localparam logic [159:0] MAXD = 160'h00FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  hash_match #(.IDX_W(32)) dut (
    .clk(clk), .rx_reset_n(rx_reset_n), .rx_done(rx_done), .rx_hash(rx_hash),
    .rx_index(rx_index), .rx_min(rx_min), .rx_max(rx_max), .rx_match_ack(rx_match_ack),
    .tx_busy(tx_busy), .tx_match_valid(tx_match_valid), .tx_match_hash(tx_match_hash),
    .tx_match_index(tx_match_index), .tx_checked_count(tx_checked_count),
    .tx_overrun(tx_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int n);
    return CE ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rx_reset_n = 1'b0; rx_done = 1'b0; rx_hash = '0; rx_index = '0;
    rx_min = '0; rx_max = '0; rx_match_ack = 1'b0;
    tick(2);
    rx_reset_n = 1'b1;
    tick(1);
    check("rst_busy", tx_busy, 0);
    check("rst_valid", tx_match_valid, 0);
    check("rst_hash", tx_match_hash, 0);
    check("rst_index", tx_match_index, 0);
    check("rst_count", tx_checked_count, 0);
    check("rst_overrun", tx_overrun, 0);

    // Exact match with min=max=hash
    rx_min = H1; rx_max = H1; rx_hash = H1; rx_index = 32'd7; rx_done = 1'b1;
    tick(1);
    check("a_busy_e0", tx_busy, 1);
    tick(4);
    check("a_valid_e4", tx_match_valid, 0);
    tick(1);
    check("a_valid_e5", tx_match_valid, 1);
    check("a_index", tx_match_index, 7);
    check("a_hash", tx_match_hash, H1);
    check("a_count", tx_checked_count, cnt(1));
    rx_done = 1'b0; rx_match_ack = 1'b1;
    tick(1);
    rx_match_ack = 1'b0;
    check("a_valid_ack", tx_match_valid, 0);
    check("a_busy_ack", tx_busy, 0);

    // max+1 on the LSW
    rx_hash = H1 + 160'd1; rx_index = 32'd8; rx_done = 1'b1;
    tick(5);
    check("b_busy_e4", tx_busy, 1);
    tick(1);
    check("b_busy_e5", tx_busy, 0);
    check("b_valid", tx_match_valid, 0);
    check("b_count", tx_checked_count, cnt(2));
    rx_done = 1'b0;
    tick(1);

    // min-1
    rx_hash = H1 - 160'd1; rx_done = 1'b1;
    tick(6);
    check("c_valid", tx_match_valid, 0);
    check("c_busy", tx_busy, 0);
    check("c_count", tx_checked_count, cnt(3));
    rx_done = 1'b0;
    tick(1);

    // min > max never matches
    rx_min = {160{1'b1}}; rx_max = '0; rx_hash = H1; rx_done = 1'b1;
    tick(6);
    check("d_valid", tx_match_valid, 0);
    check("d_count", tx_checked_count, cnt(4));
    rx_done = 1'b0;
    tick(1);

    // Range match held without ack, then a dropped candidate
    rx_min = '0; rx_max = MAXD; rx_hash = H1; rx_index = 32'd9; rx_done = 1'b1;
    tick(6);
    check("e_valid", tx_match_valid, 1);
    check("e_count", tx_checked_count, cnt(5));
    rx_done = 1'b0;
    tick(1);
    rx_hash = H2; rx_index = 32'd11; rx_done = 1'b1;
    tick(1);
    check("e_overrun", tx_overrun, 1);
    tick(17);
    check("e_valid_held", tx_match_valid, 1);
    check("e_hash_held", tx_match_hash, H1);
    check("e_index_held", tx_match_index, 9);
    check("e_count_held", tx_checked_count, cnt(5));
    // Start edge on the same edge as the ack is dropped
    rx_done = 1'b0;
    tick(1);
    rx_done = 1'b1; rx_match_ack = 1'b1;
    tick(1);
    rx_match_ack = 1'b0;
    check("e_valid_ack", tx_match_valid, 0);
    check("e_busy_ack", tx_busy, 0);
    tick(6);
    check("e_count_drop", tx_checked_count, cnt(5));
    rx_done = 1'b0;
    tick(1);

    // Reset mid-CMP, then compare from scratch
    rx_min = H1; rx_max = H1; rx_hash = H1; rx_index = 32'd3; rx_done = 1'b1;
    tick(3);
    rx_reset_n = 1'b0;
    #1;
    check("r_busy", tx_busy, 0);
    check("r_count", tx_checked_count, 0);
    check("r_overrun", tx_overrun, 0);
    check("r_valid", tx_match_valid, 0);
    rx_reset_n = 1'b1;
    tick(6);
    check("r2_valid", tx_match_valid, 1);
    check("r2_index", tx_match_index, 3);
    check("r2_count", tx_checked_count, cnt(1));
    rx_done = 1'b0; rx_match_ack = 1'b1;
    tick(1);
    rx_match_ack = 1'b0;
    check("r2_valid_ack", tx_match_valid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
